// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: Moore FSM with registered control word and a counted SRAM access.
// Optional debug pause after instruction fetch is compiled in with LC3_PAUSE_IR_EN.
module lc3_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH_MAR, S_FETCH_RD, S_FETCH_IR,
`ifdef LC3_PAUSE_IR_EN
    S_PAUSE_IR1, S_PAUSE_IR2,
`endif
    S_DECODE, S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP,
    S_JSR, S_JSR_PC, S_JSR_R, S_LDR, S_LDR_RD, S_LDR_WB,
    S_STR, S_STR_MDR, S_STR_WR, S_PAUSE1, S_PAUSE2
  } state_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       oe_n, we_n;
  } ctl_t;

  localparam ctl_t       CTL_IDLE  = 25'h3;
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctl_t       ctl_q, ctl_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HALTED:    if (Run) state_d = S_FETCH_MAR;
      S_FETCH_MAR: begin state_d = S_FETCH_RD; cnt_d = WAIT_LOAD; end
      S_FETCH_RD:  if (cnt_q == 4'd0) state_d = S_FETCH_IR; else cnt_d = cnt_q - 4'd1;
`ifdef LC3_PAUSE_IR_EN
      S_FETCH_IR:  state_d = S_PAUSE_IR1;
      S_PAUSE_IR1: if (Continue)  state_d = S_PAUSE_IR2;
      S_PAUSE_IR2: if (!Continue) state_d = S_DECODE;
`else
      S_FETCH_IR:  state_d = S_DECODE;
`endif
      S_DECODE: begin
        case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          // branch resolved here so a not-taken BR costs no extra cycle
          4'b0000: state_d = BEN ? S_BR_TAKEN : S_FETCH_MAR;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR;
          4'b0110: state_d = S_LDR;
          4'b0111: state_d = S_STR;
          4'b1101: state_d = S_PAUSE1;
          default: state_d = S_FETCH_MAR;
        endcase
      end
      S_JSR:     state_d = IR_11 ? S_JSR_PC : S_JSR_R;
      S_LDR:     begin state_d = S_LDR_RD; cnt_d = WAIT_LOAD; end
      S_LDR_RD:  if (cnt_q == 4'd0) state_d = S_LDR_WB; else cnt_d = cnt_q - 4'd1;
      S_STR:     state_d = S_STR_MDR;
      S_STR_MDR: begin state_d = S_STR_WR; cnt_d = WAIT_LOAD; end
      S_STR_WR:  if (cnt_q == 4'd0) state_d = S_FETCH_MAR; else cnt_d = cnt_q - 4'd1;
      S_PAUSE1:  if (Continue)  state_d = S_PAUSE2;
      S_PAUSE2:  if (!Continue) state_d = S_FETCH_MAR;
      S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR_PC, S_JSR_R, S_LDR_WB:
                 state_d = S_FETCH_MAR;
      default:   state_d = S_HALTED;
    endcase
  end

  // Control word for the state being entered, so outputs register alongside the state.
  always_comb begin
    ctl_d = CTL_IDLE;
    case (state_d)
      S_FETCH_MAR: begin ctl_d.g_pc = 1'b1; ctl_d.ld_mar = 1'b1; ctl_d.ld_pc = 1'b1; end
      S_FETCH_RD, S_LDR_RD: begin
        ctl_d.oe_n   = 1'b0;
        ctl_d.ld_mdr = (cnt_d == 4'd0);
      end
      S_FETCH_IR:  begin ctl_d.g_mdr = 1'b1; ctl_d.ld_ir = 1'b1; end
      S_DECODE:    ctl_d.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ctl_d.sr2mux = IR_5;
        ctl_d.aluk   = (state_d == S_ADD) ? 2'b00 : (state_d == S_AND) ? 2'b01 : 2'b10;
        ctl_d.g_alu  = 1'b1;
        ctl_d.ld_reg = 1'b1;
        ctl_d.ld_cc  = 1'b1;
      end
      S_BR_TAKEN:  begin ctl_d.addr2mux = 2'b10; ctl_d.pcmux = 2'b10; ctl_d.ld_pc = 1'b1; end
      S_JMP, S_JSR_R: begin ctl_d.addr1mux = 1'b1; ctl_d.pcmux = 2'b10; ctl_d.ld_pc = 1'b1; end
      S_JSR:       begin ctl_d.g_pc = 1'b1; ctl_d.drmux = 1'b1; ctl_d.ld_reg = 1'b1; end
      S_JSR_PC:    begin ctl_d.addr2mux = 2'b11; ctl_d.pcmux = 2'b10; ctl_d.ld_pc = 1'b1; end
      S_LDR, S_STR: begin
        ctl_d.addr1mux = 1'b1;
        ctl_d.addr2mux = 2'b01;
        ctl_d.g_marmux = 1'b1;
        ctl_d.ld_mar   = 1'b1;
      end
      S_LDR_WB:    begin ctl_d.g_mdr = 1'b1; ctl_d.ld_reg = 1'b1; ctl_d.ld_cc = 1'b1; end
      S_STR_MDR: begin
        ctl_d.sr1mux = 1'b1;
        ctl_d.aluk   = 2'b11;
        ctl_d.g_alu  = 1'b1;
        ctl_d.ld_mdr = 1'b1;
      end
      S_STR_WR:    ctl_d.we_n = 1'b0;
      S_PAUSE1:    ctl_d.ld_led = (state_q == S_DECODE);
      default:     ctl_d = CTL_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_HALTED;
      cnt_q   <= 4'd0;
      ctl_q   <= CTL_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign LD_MAR     = ctl_q.ld_mar;
  assign LD_MDR     = ctl_q.ld_mdr;
  assign LD_IR      = ctl_q.ld_ir;
  assign LD_BEN     = ctl_q.ld_ben;
  assign LD_CC      = ctl_q.ld_cc;
  assign LD_REG     = ctl_q.ld_reg;
  assign LD_PC      = ctl_q.ld_pc;
  assign LD_LED     = ctl_q.ld_led;
  assign GatePC     = ctl_q.g_pc;
  assign GateMDR    = ctl_q.g_mdr;
  assign GateALU    = ctl_q.g_alu;
  assign GateMARMUX = ctl_q.g_marmux;
  assign PCMUX      = ctl_q.pcmux;
  assign DRMUX      = ctl_q.drmux;
  assign SR1MUX     = ctl_q.sr1mux;
  assign SR2MUX     = ctl_q.sr2mux;
  assign ADDR1MUX   = ctl_q.addr1mux;
  assign ADDR2MUX   = ctl_q.addr2mux;
  assign ALUK       = ctl_q.aluk;
  assign Mem_OE     = ctl_q.oe_n;
  assign Mem_WE     = ctl_q.we_n;
  assign Mem_CE     = 1'b0;
  assign Mem_UB     = 1'b0;
  assign Mem_LB     = 1'b0;

endmodule

// File: tb/tb_lc3_sequencer.sv
// Randomized bench for lc3_sequencer: one instance per MEM_WAIT, each checked cycle by cycle
// against a per-instruction control-word trace built from the instruction set's rules.
module tb_lc3_sequencer;
  localparam int NI = 5;
  localparam int MWS [NI] = '{1, 2, 3, 4, 15};

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       ce, ub, lb, oe, we;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n [NI];
  logic       run   [NI];
  logic       cont  [NI];
  logic [3:0] op    [NI];
  logic       ir5   [NI];
  logic       ir11  [NI];
  logic       ben   [NI];
  ctl_t       obs   [NI];

  int   n_chk = 0;
  int   n_err = 0;
  ctl_t exp_q [$];
  logic cont_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic g_pc, g_mdr, g_alu, g_marmux, drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic ce, ub, lb, oe, we;
    lc3_sequencer #(.MEM_WAIT(MWS[g])) u_dut (
      .Clk(clk), .Reset_n(rst_n[g]), .Run(run[g]), .Continue(cont[g]),
      .Opcode(op[g]), .IR_5(ir5[g]), .IR_11(ir11[g]), .BEN(ben[g]),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(g_pc), .GateMDR(g_mdr), .GateALU(g_alu), .GateMARMUX(g_marmux),
      .PCMUX(pcmux), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
      .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux), .ALUK(aluk),
      .Mem_CE(ce), .Mem_UB(ub), .Mem_LB(lb), .Mem_OE(oe), .Mem_WE(we)
    );
    assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                     g_pc, g_mdr, g_alu, g_marmux, pcmux, drmux, sr1mux, sr2mux,
                     addr1mux, addr2mux, aluk, ce, ub, lb, oe, we};
  end

  function automatic ctl_t idle();
    ctl_t c;
    c    = '0;
    c.oe = 1'b1;
    c.we = 1'b1;
    return c;
  endfunction

  task automatic chk(input string tag, input ctl_t got, input ctl_t want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input ctl_t w, input logic c);
    exp_q.push_back(w);
    cont_q.push_back(c);
  endtask

  // Expected control word per cycle, from FETCH_MAR entry to just before the next fetch.
  // a/b: extra cycles Continue is held at 0 in PAUSE1 and at 1 in PAUSE2.
  task automatic build(input int mw, input logic [3:0] opc, input logic i5, input logic i11,
                       input logic bn, input int a, input int b);
    ctl_t w;
    exp_q.delete();
    cont_q.delete();
    w = idle(); w.g_pc = 1; w.ld_mar = 1; w.ld_pc = 1; push(w, 1'($urandom));
    for (int i = 0; i < mw; i++) begin
      w = idle(); w.oe = 0; w.ld_mdr = (i == mw - 1); push(w, 1'($urandom));
    end
    w = idle(); w.g_mdr = 1; w.ld_ir = 1; push(w, 1'($urandom));
    w = idle(); w.ld_ben = 1; push(w, 1'($urandom));
    case (opc)
      4'h1, 4'h5, 4'h9: begin
        w = idle(); w.sr2mux = i5; w.g_alu = 1; w.ld_reg = 1; w.ld_cc = 1;
        w.aluk = (opc == 4'h1) ? 2'd0 : (opc == 4'h5) ? 2'd1 : 2'd2;
        push(w, 1'($urandom));
      end
      4'h0: if (bn) begin
        w = idle(); w.addr2mux = 2; w.pcmux = 2; w.ld_pc = 1; push(w, 1'($urandom));
      end
      4'hC: begin
        w = idle(); w.addr1mux = 1; w.pcmux = 2; w.ld_pc = 1; push(w, 1'($urandom));
      end
      4'h4: begin
        w = idle(); w.g_pc = 1; w.drmux = 1; w.ld_reg = 1; push(w, 1'($urandom));
        w = idle(); w.pcmux = 2; w.ld_pc = 1;
        if (i11) w.addr2mux = 3; else w.addr1mux = 1;
        push(w, 1'($urandom));
      end
      4'h6, 4'h7: begin
        w = idle(); w.addr1mux = 1; w.addr2mux = 1; w.g_marmux = 1; w.ld_mar = 1;
        push(w, 1'($urandom));
        if (opc == 4'h6) begin
          for (int i = 0; i < mw; i++) begin
            w = idle(); w.oe = 0; w.ld_mdr = (i == mw - 1); push(w, 1'($urandom));
          end
          w = idle(); w.g_mdr = 1; w.ld_reg = 1; w.ld_cc = 1; push(w, 1'($urandom));
        end else begin
          w = idle(); w.sr1mux = 1; w.aluk = 3; w.g_alu = 1; w.ld_mdr = 1;
          push(w, 1'($urandom));
          for (int i = 0; i < mw; i++) begin
            w = idle(); w.we = 0; push(w, 1'($urandom));
          end
        end
      end
      4'hD: begin
        for (int i = 0; i <= a; i++) begin
          w = idle(); w.ld_led = (i == 0); push(w, (i == a));
        end
        for (int i = 0; i <= b; i++) push(idle(), (i != b));
      end
      default: ;
    endcase
  endtask

  // Entered at a falling edge with the DUT in FETCH_MAR; leaves at the next FETCH_MAR.
  task automatic run_instr(input int k, input logic [3:0] opc, input logic i5,
                           input logic i11, input logic bn);
    build(MWS[k], opc, i5, i11, bn, $urandom_range(0, 3), $urandom_range(0, 3));
    op[k] = opc; ir5[k] = i5; ir11[k] = i11; ben[k] = bn;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("mw%0d op%h cyc%0d", MWS[k], opc, i), obs[k], exp_q[i]);
      cont[k] = cont_q[i];
      run[k]  = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_inst(input int k);
    ctl_t w;
    logic [3:0] legal [10];
    legal = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h4, 4'h6, 4'h7, 4'hD, 4'hF};
    @(negedge clk);
    rst_n[k] = 1'b1; run[k] = 1'b0; cont[k] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk($sformatf("mw%0d halted", MWS[k]), obs[k], idle());
    end
    run[k] = 1'b1;
    @(negedge clk);
    run_instr(k, 4'h1, 1, 0, 0);
    run_instr(k, 4'h0, 0, 0, 0);
    run_instr(k, 4'h0, 0, 0, 1);
    run_instr(k, 4'h7, 0, 0, 0);
    run_instr(k, 4'h4, 0, 0, 0);
    run_instr(k, 4'h4, 0, 1, 0);
    run_instr(k, 4'hD, 0, 0, 0);
    run_instr(k, 4'hF, 0, 0, 0);
    run_instr(k, 4'h6, 0, 0, 0);
    run_instr(k, 4'hC, 0, 0, 0);
    repeat (30) begin
      logic [3:0] o;
      o = $urandom_range(0, 1) ? legal[$urandom_range(0, 9)] : 4'($urandom);
      run_instr(k, o, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    // abort an instruction fetch mid-read
    @(negedge clk);
    w = idle(); w.oe = 0; w.ld_mdr = (MWS[k] == 1);
    chk($sformatf("mw%0d rd_pre_rst", MWS[k]), obs[k], w);
    #2 rst_n[k] = 1'b0;
    #1 chk($sformatf("mw%0d rst_async", MWS[k]), obs[k], idle());
    run[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("mw%0d rst_hold", MWS[k]), obs[k], idle());
    rst_n[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("mw%0d rst_halted", MWS[k]), obs[k], idle());
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; run[k] = 1'b0; cont[k] = 1'b0;
      op[k] = 4'h0; ir5[k] = 1'b0; ir11[k] = 1'b0; ben[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk($sformatf("mw%0d reset", MWS[k]), obs[k], idle());
    for (int k = 0; k < NI; k++) test_inst(k);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
